// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table evaluation blocks: FSM state encoding and table width.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N_IN = 4;

    // One table bit per input combination.
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Per-vector hold counter: counts 0..SETTLE_CYCLES while enabled and flags the sample cycle.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(SETTLE_CYCLES);

    logic [7:0] hold_cnt;

    assign tc = (hold_cnt == TC_VAL);

    // Restart at zero on load; wrap back to zero on the sample cycle.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            hold_cnt <= 8'd0;
        end else if (enable) begin
            if (tc) begin
                hold_cnt <= 8'd0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps a combinational gate through every input vector, captures its truth table and
// compares it against a golden table latched at start.
module truth_table_sweep_ctrl
    import tt_pkg::*;
#(
    parameter  int N_IN          = DEFAULT_N_IN,
    parameter  int SETTLE_CYCLES = 3,
    localparam int TT_W          = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] result,
    output logic [TT_W-1:0] mismatch_mask,
    output logic            mismatch
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t          state;
    state_t          state_next;
    logic [TT_W-1:0] exp_latched;
    logic [TT_W-1:0] result_next;
    logic            tc;
    logic            start_ok;
    logic            abort_ok;
    logic            sample;
    logic            last_sample;

    // Abort outranks both a start in IDLE and the sample edge in RUN.
    assign start_ok    = (state == ST_IDLE) && start && !abort;
    assign abort_ok    = (state == ST_RUN) && abort;
    assign sample      = (state == ST_RUN) && !abort && tc;
    assign last_sample = sample && (dut_in == LAST_VEC);

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (start_ok || abort_ok),
        .enable (state == ST_RUN),
        .tc     (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort_ok) begin
                    state_next = ST_IDLE;
                end else if (last_sample) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture view including the bit being sampled this cycle, so the final compare sees it.
    always_comb begin
        result_next         = result;
        result_next[dut_in] = dut_out;
    end

    // Mismatch outputs only move at completion; start and abort leave them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in        <= '0;
            result        <= '0;
            exp_latched   <= '0;
            mismatch_mask <= '0;
            mismatch      <= 1'b0;
        end else if (start_ok) begin
            exp_latched <= expected;
            dut_in      <= '0;
            result      <= '0;
        end else if (abort_ok) begin
            dut_in <= '0;
        end else if (sample) begin
            result <= result_next;
            dut_in <= dut_in + N_IN'(1);
            if (last_sample) begin
                mismatch_mask <= result_next ^ exp_latched;
                mismatch      <= |(result_next ^ exp_latched);
            end
        end
    end

endmodule
